// File: rtl/shifter_rr_arbiter_if.sv
// rtl/shifter_rr_arbiter_if.sv - request/response bundle for the shared shifter arbiter
interface shifter_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 22
);
  localparam int SHIFT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ*SHIFT_W-1:0]    req_shift_i;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic [ID_W-1:0]               rsp_id_o;

  // requester/consumer side
  modport master (
    output req_valid_i, req_data_i, req_shift_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o
  );

  // arbiter side
  modport slave (
    input  req_valid_i, req_data_i, req_shift_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o
  );
endinterface

// File: rtl/shifter_rr_arbiter.sv
// rtl/shifter_rr_arbiter.sv - round-robin arbiter sharing one arithmetic right shifter
module shifter_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 22
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  shifter_rr_arbiter_if.slave  bus
);
  localparam int SHIFT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Largest useful shift; anything beyond just replicates the sign bit.
  localparam logic [SHIFT_W-1:0] MAX_SHIFT = SHIFT_W'(DATA_WIDTH - 1);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            state;
  logic [ID_W-1:0]       ptr;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ID_W-1:0]       rsp_id;

  logic                  can_accept;
  logic                  any_valid;
  logic [NUM_REQ-1:0]    hi_mask;
  logic [NUM_REQ-1:0]    valid_hi;
  logic [ID_W-1:0]       sel_hi;
  logic [ID_W-1:0]       sel_lo;
  logic [ID_W-1:0]       sel_id;
  logic [NUM_REQ-1:0]    grant;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [SHIFT_W-1:0]    sel_shift;
  logic [SHIFT_W-1:0]    eff_shift;
  logic [DATA_WIDTH-1:0] shifted;
  logic [ID_W-1:0]       ptr_next;

  // The result slot is free when empty or when it drains on this edge.
  always_comb begin
    can_accept = (state == ST_EMPTY) || bus.rsp_ready_i;
    any_valid  = |bus.req_valid_i;
  end

  // Requesters at or above the pointer get first pick; the rest wrap around.
  always_comb begin
    hi_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      hi_mask[k] = (ID_W'(k) >= ptr);
    end
    valid_hi = bus.req_valid_i & hi_mask;
  end

  // Lowest-index valid requester in the upper window and overall; the
  // wrap-around choice is the lowest overall when the upper window is empty.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_hi[k]) begin
        sel_hi = ID_W'(k);
      end
      if (bus.req_valid_i[k]) begin
        sel_lo = ID_W'(k);
      end
    end
    sel_id = (|valid_hi) ? sel_hi : sel_lo;
  end

  // One-hot accept strobe; sel_id always points at a valid requester when any is set.
  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant[k] = rstn_i && can_accept && any_valid && (sel_id == ID_W'(k));
    end
    handshake = |grant;
  end

  // Route the winning operand into the single shared shifter.
  always_comb begin
    sel_data  = '0;
    sel_shift = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel_id == ID_W'(k)) begin
        sel_data  = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_shift = bus.req_shift_i[k*SHIFT_W +: SHIFT_W];
      end
    end
  end

  // Clamp the count so oversized shifts saturate to pure sign fill.
  always_comb begin
    eff_shift = (sel_shift > MAX_SHIFT) ? MAX_SHIFT : sel_shift;
    shifted   = $signed(sel_data) >>> eff_shift;
    ptr_next  = (sel_id == LAST_ID) ? '0 : sel_id + ID_W'(1);
  end

  // Control: fill on handshake, drain when consumed with nothing new arriving.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= ST_EMPTY;
      ptr   <= '0;
    end else if (handshake) begin
      state <= ST_FULL;
      ptr   <= ptr_next;
    end else if ((state == ST_FULL) && bus.rsp_ready_i) begin
      state <= ST_EMPTY;
    end
  end

  // Result register only loads on a handshake, so it holds through stalls and idle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (handshake) begin
      rsp_data <= shifted;
      rsp_id   <= sel_id;
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.rsp_valid_o = (state == ST_FULL);
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_id_o    = rsp_id;
endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// tb/tb_shifter_rr_arbiter.sv - self-checking bench for shifter_rr_arbiter
module tb_shifter_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 22;
  localparam int SW = 5;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic [SW-1:0] shift;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    id;
  } sb_t;

  logic clk;
  logic rstn;

  shifter_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  shifter_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sb_t           sb[$];
  logic          m_full;
  int            m_ptr;
  logic [DW-1:0] m_last_data;
  logic [1:0]    m_last_id;
  logic          use_tbl;
  logic [DW-1:0] tbl_exp;
  logic [NR-1:0] last_ready_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference shifter: one sign-filling step at a time, clamped at DW-1 steps.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [DW-1:0] r;
    int n;
    r = d;
    n = (int'(s) > DW - 1) ? DW - 1 : int'(s);
    for (int i = 0; i < n; i++) r = {r[DW-1], r[DW-1:1]};
    return r;
  endfunction

  task automatic model_reset();
    m_full      = 1'b0;
    m_ptr       = 0;
    m_last_data = '0;
    m_last_id   = '0;
    sb.delete();
  endtask

  // Drive one cycle (called just after a rising edge), check grant mid-cycle,
  // check the result register just after the next rising edge.
  task automatic cycle(input logic [NR-1:0] valid, input logic rsp_rdy);
    logic [NR-1:0] exp_ready;
    logic          hs;
    int            g;
    int            k;
    sb_t           e;
    bus.req_valid_i = valid;
    bus.rsp_ready_i = rsp_rdy;
    @(negedge clk);
    exp_ready = '0;
    hs = 1'b0;
    g = 0;
    if (!m_full || rsp_rdy) begin
      for (int i = 0; i < NR; i++) begin
        k = (m_ptr + i) % NR;
        if (!hs && valid[k]) begin
          hs = 1'b1;
          g = k;
        end
      end
    end
    if (hs) exp_ready[g] = 1'b1;
    last_ready_seen = bus.req_ready_o;
    chk("req_ready", 32'(bus.req_ready_o), 32'(exp_ready));
    if (hs) begin
      e.data = use_tbl ? tbl_exp : ref_shift(bus.req_data_i[g*DW +: DW], bus.req_shift_i[g*SW +: SW]);
      e.id   = 2'(g);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (hs) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        m_last_data = e.data;
        m_last_id   = e.id;
      end
      m_full = 1'b1;
      m_ptr  = (g + 1) % NR;
    end else if (m_full && rsp_rdy) begin
      m_full = 1'b0;
    end
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_full));
    chk("rsp_data", 32'(bus.rsp_data_o), 32'(m_last_data));
    chk("rsp_id", 32'(bus.rsp_id_o), 32'(m_last_id));
  endtask

  vec_t vecs[10];
  int   exp_grants[6];

  initial begin
    vecs[0] = '{0, 22'h200000, 5'd3,  22'h3C0000};
    vecs[1] = '{1, 22'h100000, 5'd31, 22'h000000};
    vecs[2] = '{2, 22'h2FFFFF, 5'd22, 22'h3FFFFF};
    vecs[3] = '{3, 22'h2FFFFF, 5'd21, 22'h3FFFFF};
    vecs[4] = '{0, 22'h0ABCDE, 5'd4,  22'h00ABCD};
    vecs[5] = '{2, 22'h3FFFFF, 5'd0,  22'h3FFFFF};
    vecs[6] = '{1, 22'h123456, 5'd0,  22'h123456};
    vecs[7] = '{0, 22'h200001, 5'd1,  22'h300000};
    vecs[8] = '{1, 22'h3FFFF0, 5'd2,  22'h3FFFFC};
    vecs[9] = '{3, 22'h1FFFFF, 5'd21, 22'h000000};
    exp_grants = '{0, 1, 2, 3, 0, 1};

    use_tbl = 1'b0;
    tbl_exp = '0;
    last_ready_seen = '0;
    model_reset();

    // reset state, with requests pending
    rstn = 1'b0;
    bus.req_valid_i = 4'b1111;
    bus.req_data_i  = '0;
    bus.req_shift_i = '0;
    bus.rsp_ready_i = 1'b1;
    #3;
    chk("reset_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset_data", 32'(bus.rsp_data_o), 32'd0);
    chk("reset_id", 32'(bus.rsp_id_o), 32'd0);
    chk("reset_ready", 32'(bus.req_ready_o), 32'd0);
    bus.req_valid_i = '0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // table: single requester, always-ready consumer
    use_tbl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.req_data_i[vecs[i].id*DW +: DW]  = vecs[i].data;
      bus.req_shift_i[vecs[i].id*SW +: SW] = vecs[i].shift;
      tbl_exp = vecs[i].exp;
      cycle(NR'(1) << vecs[i].id, 1'b1);
      chk("tbl_ready", 32'(last_ready_seen), 32'(NR'(1) << vecs[i].id));
    end
    use_tbl = 1'b0;

    // all four requesting: rotating grants, one result per cycle
    for (int i = 0; i < NR; i++) begin
      bus.req_data_i[i*DW +: DW]  = DW'($urandom);
      bus.req_shift_i[i*SW +: SW] = SW'($urandom_range(0, 31));
    end
    for (int i = 0; i < 6; i++) begin
      cycle(4'b1111, 1'b1);
      chk("rr_grant", 32'(last_ready_seen), 32'(NR'(1) << exp_grants[i]));
      chk("rr_id", 32'(bus.rsp_id_o), 32'(exp_grants[i]));
    end

    // drain with no request: EMPTY, last result held
    cycle(4'b0000, 1'b1);

    // backpressure: fill from requester 0, then stall with 1 and 2 waiting
    cycle(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0110, 1'b0);
      chk("stall_ready", 32'(last_ready_seen), 32'd0);
    end
    cycle(4'b0110, 1'b1);
    chk("drain_accept", 32'(last_ready_seen), 32'b0010);

    // a requester withdrawing without handshake leaves no trace
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b1);

    // pointer wrap 3 -> 0 with no idle cycle
    cycle(4'b1000, 1'b1);
    chk("wrap_g3", 32'(last_ready_seen), 32'b1000);
    cycle(4'b0001, 1'b1);
    chk("wrap_g0", 32'(last_ready_seen), 32'b0001);
    chk("wrap_id", 32'(bus.rsp_id_o), 32'd0);

    // mid-cycle reset while FULL and stalled
    cycle(4'b0000, 1'b0);
    #2;
    bus.req_valid_i = 4'b1111;
    rstn = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("midrst_data", 32'(bus.rsp_data_o), 32'd0);
    chk("midrst_id", 32'(bus.rsp_id_o), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready_o), 32'd0);
    bus.req_valid_i = '0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cycle(4'b1100, 1'b1);
    chk("post_rst_grant", 32'(last_ready_seen), 32'b0100);
    cycle(4'b1100, 1'b1);
    chk("post_rst_next", 32'(last_ready_seen), 32'b1000);
    cycle(4'b0000, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shifter_rr_arbiter.md
SHIFTER_RR_ARBITER -- requirements
Module: shifter_rr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the shifter (2..16).
REQ-002 Parameter DATA_WIDTH, default 22, two's-complement sample width.
REQ-003 Local constants:
  - SHIFT_W = ceil(log2(DATA_WIDTH)), minimum 1.
  - ID_W = ceil(log2(NUM_REQ)), minimum 1.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready_o  output  NUM_REQ  per-requester accept strobe.
REQ-008 req_data_i  input  NUM_REQ*DATA_WIDTH  packed signed operands; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_shift_i  input  NUM_REQ*SHIFT_W  packed unsigned right-shift counts; requester k at [k*SHIFT_W +: SHIFT_W].
REQ-010 rsp_valid_o  output  1  result register holds a valid result.
REQ-011 rsp_ready_i  input  1  downstream accepts the result.
REQ-012 rsp_data_o  output  DATA_WIDTH  signed shifted result.
REQ-013 rsp_id_o  output  ID_W  index of the requester that produced rsp_data_o.

Function
REQ-014 The block shall contain exactly one arithmetic right shifter: sign-filling, result = operand >>> effective shift.
REQ-015 Effective shift shall be min(req_shift, DATA_WIDTH-1). Counts >= DATA_WIDTH yield all sign bits: 0 for non-negative operands, all ones for negative operands.
REQ-016 Control is two states:
  - EMPTY (rsp_valid_o=0).
  - FULL (rsp_valid_o=1).
REQ-017 can_accept = EMPTY or (FULL and rsp_ready_i).
REQ-018 Grant is round-robin.
  - The selected requester is the first k with req_valid_i[k]=1, scanning from pointer ptr upward modulo NUM_REQ.
REQ-019 req_ready_o shall be one-hot on the selected requester when can_accept=1 and any req_valid_i is set; otherwise all zero. req_ready_o is combinational.
REQ-020 A handshake on requester k (valid and ready both high at a clock edge) shall, at that edge:
  - load the shifted result and k into rsp_data_o and rsp_id_o;
  - set FULL;
  - set ptr to (k+1) mod NUM_REQ.
REQ-021 Latency is one cycle: the result is visible on the cycle after the accepting edge.
REQ-022 Throughput is one result per cycle while rsp_ready_i=1.
REQ-023 FULL with rsp_ready_i=1 and no request: go to EMPTY; rsp_data_o and rsp_id_o hold their last values.
REQ-024 FULL with rsp_ready_i=0: hold rsp_valid_o, rsp_data_o and rsp_id_o stable; all req_ready_o=0; ptr unchanged.
REQ-025 ptr shall change only on a handshake. Idle cycles and stalls never advance it.
REQ-026 A requester lowering valid without a handshake is legal and leaves no side effect.
REQ-027 req_ready_o shall never assert for a requester whose req_valid_i is 0.

Reset
REQ-028 While rstn_i=0, asynchronously and at once:
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0;
  - ptr=0, state EMPTY;
  - req_ready_o=0.
REQ-029 Reset during FULL shall drop the pending result with no handshake. The first edge after release starts in EMPTY with ptr=0.

Verification (NUM_REQ=4, DATA_WIDTH=22)
REQ-030 Requester 0, data 0x200000, shift 3, rsp_ready_i=1 -> req_ready_o=4'b0001 that cycle; next cycle rsp_valid_o=1, rsp_data_o=0x3C0000, rsp_id_o=0.
REQ-031 All four valid for 6 cycles, rsp_ready_i=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id_o follows one cycle later.
REQ-032 Saturation cases:
  - data 0x100000, shift 31 -> rsp_data_o=0x000000.
  - data 0x2FFFFF, shift 22 -> rsp_data_o=0x3FFFFF.
  - data 0x2FFFFF, shift 21 -> rsp_data_o=0x3FFFFF.
REQ-033 Backpressure: result FULL, rsp_ready_i=0 for 3 cycles, requesters 1 and 2 valid -> outputs stable and req_ready_o=0 for 3 cycles. On the cycle rsp_ready_i rises, req_ready_o=4'b0010: drain and accept happen on the same edge.
REQ-034 rstn_i pulsed low mid-cycle while FULL -> rsp_valid_o falls before the next edge. After release, requesters 2 and 3 valid -> requester 2 granted first.
REQ-035 Only requester 3 valid, then only requester 0 valid -> ptr wraps 3 to 0; grant 0 with no idle cycle.
